// File: rtl/tst_dout_stat.sv
// Output-monitor statistics block: picks up window updates from the fast-domain
// monitor through a toggle synchronizer and keeps window values, saturating
// totals, the first-output latency and a small run-state FSM.
module tst_dout_stat #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ACCW        = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              mon_vld_tgl,
    input  logic [6:0]        mon_cnt,
    input  logic [6:0]        mon_err,
    input  logic [11:0]       mon_idl,
    input  logic [15:0]       mon_lat,
    input  logic              mon_done,
    output logic              upd,
    output logic [6:0]        win_cnt,
    output logic [6:0]        win_err,
    output logic [11:0]       win_idl,
    output logic [ACCW-1:0]   tot_vld,
    output logic [ACCW-1:0]   tot_err,
    output logic [ACCW+7:0]   tot_idl,
    output logic [15:0]       lat,
    output logic              sat,
    output logic              err_sticky,
    output logic [1:0]        state,
    output logic              pass
);

    localparam int unsigned IDLW  = ACCW + 8;
    localparam int unsigned SUMW  = ACCW + 1;
    localparam int unsigned ISUMW = IDLW + 1;
    localparam int unsigned ARMW  = 3;

    // Edges to let the chain settle after reset so the initial toggle level is ignored
    localparam logic [ARMW-1:0] ARM_DONE = ARMW'(SYNC_STAGES + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [ARMW-1:0]        arm_q, arm_d;
    logic                   upd_det;

    logic              upd_q, upd_d;
    logic [6:0]        win_cnt_q, win_cnt_d;
    logic [6:0]        win_err_q, win_err_d;
    logic [11:0]       win_idl_q, win_idl_d;
    logic [ACCW-1:0]   tot_vld_q, tot_vld_d;
    logic [ACCW-1:0]   tot_err_q, tot_err_d;
    logic [IDLW-1:0]   tot_idl_q, tot_idl_d;
    logic [15:0]       lat_q, lat_d;
    logic              sat_q, sat_d;
    logic              err_sticky_q, err_sticky_d;
    logic [1:0]        state_q, state_d;
    logic              pass_q, pass_d;

    logic [SUMW-1:0]   vld_sum;
    logic [SUMW-1:0]   err_sum;
    logic [ISUMW-1:0]  idl_sum;
    logic [ACCW-1:0]   vld_nxt;
    logic [ACCW-1:0]   err_nxt;
    logic [IDLW-1:0]   idl_nxt;
    logic              any_ovf;
    logic              acc_en;

    // Toggle synchronizer, delay flop and post-reset arming counter
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], mon_vld_tgl};
        dly_d  = sync_q[SYNC_STAGES-1];
        arm_d  = (arm_q == ARM_DONE) ? arm_q : arm_q + ARMW'(1);
    end

    assign upd_det = (arm_q == ARM_DONE) && (sync_q[SYNC_STAGES-1] ^ dly_q);

    // Synchronizer registers; untouched by clr
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            arm_q  <= '0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            arm_q  <= arm_d;
        end
    end

    // Saturating adders: one extra bit catches the carry, which clamps to all-ones
    always_comb begin
        vld_sum = {1'b0, tot_vld_q} + SUMW'(mon_cnt);
        err_sum = {1'b0, tot_err_q} + SUMW'(mon_err);
        idl_sum = {1'b0, tot_idl_q} + ISUMW'(mon_idl);
        vld_nxt = vld_sum[SUMW-1] ? '1 : vld_sum[ACCW-1:0];
        err_nxt = err_sum[SUMW-1] ? '1 : err_sum[ACCW-1:0];
        idl_nxt = idl_sum[ISUMW-1] ? '1 : idl_sum[IDLW-1:0];
        any_ovf = vld_sum[SUMW-1] | err_sum[SUMW-1] | idl_sum[ISUMW-1];
    end

    // Next-state for FSM, captures and accumulators
    always_comb begin
        upd_d        = 1'b0;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        win_idl_d    = win_idl_q;
        tot_vld_d    = tot_vld_q;
        tot_err_d    = tot_err_q;
        tot_idl_d    = tot_idl_q;
        lat_d        = lat_q;
        sat_d        = sat_q;
        err_sticky_d = err_sticky_q;
        state_d      = state_q;
        acc_en       = 1'b0;

        if (clr) begin
            win_cnt_d    = '0;
            win_err_d    = '0;
            win_idl_d    = '0;
            tot_vld_d    = '0;
            tot_err_d    = '0;
            tot_idl_d    = '0;
            lat_d        = '0;
            sat_d        = 1'b0;
            err_sticky_d = 1'b0;
            state_d      = ST_IDLE;
        end else if (upd_det) begin
            upd_d     = 1'b1;
            win_cnt_d = mon_cnt;
            win_err_d = mon_err;
            win_idl_d = mon_idl;

            case (state_q)
                ST_IDLE: state_d = ST_WAIT;
                ST_WAIT: if (mon_cnt != 7'd0) state_d = ST_RUN;
                ST_RUN:  if (mon_done && (mon_cnt == 7'd0)) state_d = ST_DONE;
                ST_DONE: if (mon_cnt != 7'd0) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase

            // Windows count while running, including the one that (re)starts the run
            acc_en = (state_q == ST_RUN) || (state_d == ST_RUN);
            if (acc_en) begin
                tot_vld_d = vld_nxt;
                tot_err_d = err_nxt;
                tot_idl_d = idl_nxt;
                if (any_ovf) sat_d = 1'b1;
            end

            if ((state_q == ST_WAIT) || (state_q == ST_RUN)) lat_d = mon_lat;
            if ((state_q != ST_IDLE) && (mon_err != 7'd0)) err_sticky_d = 1'b1;
        end

        pass_d = (state_d == ST_DONE) && (tot_err_d == '0) && (tot_vld_d != '0);
    end

    // Statistics and FSM registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            upd_q        <= 1'b0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            win_idl_q    <= '0;
            tot_vld_q    <= '0;
            tot_err_q    <= '0;
            tot_idl_q    <= '0;
            lat_q        <= '0;
            sat_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            state_q      <= ST_IDLE;
            pass_q       <= 1'b0;
        end else begin
            upd_q        <= upd_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            win_idl_q    <= win_idl_d;
            tot_vld_q    <= tot_vld_d;
            tot_err_q    <= tot_err_d;
            tot_idl_q    <= tot_idl_d;
            lat_q        <= lat_d;
            sat_q        <= sat_d;
            err_sticky_q <= err_sticky_d;
            state_q      <= state_d;
            pass_q       <= pass_d;
        end
    end

    assign upd        = upd_q;
    assign win_cnt    = win_cnt_q;
    assign win_err    = win_err_q;
    assign win_idl    = win_idl_q;
    assign tot_vld    = tot_vld_q;
    assign tot_err    = tot_err_q;
    assign tot_idl    = tot_idl_q;
    assign lat        = lat_q;
    assign sat        = sat_q;
    assign err_sticky = err_sticky_q;
    assign state      = state_q;
    assign pass       = pass_q;

endmodule

// File: tb/tb_tst_dout_stat.sv
// Bench for tst_dout_stat: directed scenarios plus random windows, compared
// against a window-level reference model for a 32-bit and an 8-bit instance.
module tb_tst_dout_stat;

    localparam int unsigned SYNC = 2;

    logic        clk;
    logic        rstn;
    logic        clr;
    logic        mon_vld_tgl;
    logic [6:0]  mon_cnt;
    logic [6:0]  mon_err;
    logic [11:0] mon_idl;
    logic [15:0] mon_lat;
    logic        mon_done;

    logic        upd, sat, err_sticky, pass;
    logic [6:0]  win_cnt, win_err;
    logic [11:0] win_idl;
    logic [31:0] tot_vld, tot_err;
    logic [39:0] tot_idl;
    logic [15:0] lat;
    logic [1:0]  state;

    logic        upd8, sat8, err_sticky8, pass8;
    logic [6:0]  win_cnt8, win_err8;
    logic [11:0] win_idl8;
    logic [7:0]  tot_vld8, tot_err8;
    logic [15:0] tot_idl8;
    logic [15:0] lat8;
    logic [1:0]  state8;

    tst_dout_stat #(.SYNC_STAGES(SYNC), .ACCW(32)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .mon_vld_tgl(mon_vld_tgl),
        .mon_cnt(mon_cnt), .mon_err(mon_err), .mon_idl(mon_idl), .mon_lat(mon_lat),
        .mon_done(mon_done), .upd(upd), .win_cnt(win_cnt), .win_err(win_err),
        .win_idl(win_idl), .tot_vld(tot_vld), .tot_err(tot_err), .tot_idl(tot_idl),
        .lat(lat), .sat(sat), .err_sticky(err_sticky), .state(state), .pass(pass)
    );

    tst_dout_stat #(.SYNC_STAGES(SYNC), .ACCW(8)) dut8 (
        .clk(clk), .rstn(rstn), .clr(clr), .mon_vld_tgl(mon_vld_tgl),
        .mon_cnt(mon_cnt), .mon_err(mon_err), .mon_idl(mon_idl), .mon_lat(mon_lat),
        .mon_done(mon_done), .upd(upd8), .win_cnt(win_cnt8), .win_err(win_err8),
        .win_idl(win_idl8), .tot_vld(tot_vld8), .tot_err(tot_err8), .tot_idl(tot_idl8),
        .lat(lat8), .sat(sat8), .err_sticky(err_sticky8), .state(state8), .pass(pass8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_upd = 0;

    // Reference model state (window level)
    int              m_state;
    int              m_wcnt, m_werr, m_widl, m_lat;
    longint unsigned m_vld, m_err, m_idl, m_vld8, m_err8, m_idl8;
    bit              m_sat, m_sat8, m_errs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_wcnt = 0; m_werr = 0; m_widl = 0; m_lat = 0;
        m_vld = 0; m_err = 0; m_idl = 0; m_vld8 = 0; m_err8 = 0; m_idl8 = 0;
        m_sat = 0; m_sat8 = 0; m_errs = 0;
    endtask

    function automatic longint unsigned sadd(input longint unsigned a, input longint unsigned b,
                                             input longint unsigned mx, inout bit s);
        if (a + b > mx) begin
            s = 1'b1;
            return mx;
        end
        return a + b;
    endfunction

    task automatic model_win(input int cnt, input int err, input int idl, input int lt, input bit done);
        int nxt;
        m_wcnt = cnt; m_werr = err; m_widl = idl;
        nxt = m_state;
        if (m_state == 0) nxt = 1;
        else if (m_state == 1 && cnt != 0) nxt = 2;
        else if (m_state == 2 && done && cnt == 0) nxt = 3;
        else if (m_state == 3 && cnt != 0) nxt = 2;
        if (m_state == 2 || nxt == 2) begin
            m_vld  = sadd(m_vld,  cnt, 64'hFFFF_FFFF,   m_sat);
            m_err  = sadd(m_err,  err, 64'hFFFF_FFFF,   m_sat);
            m_idl  = sadd(m_idl,  idl, 64'hFF_FFFF_FFFF, m_sat);
            m_vld8 = sadd(m_vld8, cnt, 64'hFF,          m_sat8);
            m_err8 = sadd(m_err8, err, 64'hFF,          m_sat8);
            m_idl8 = sadd(m_idl8, idl, 64'hFFFF,        m_sat8);
        end
        if (m_state == 1 || m_state == 2) m_lat = lt;
        if (m_state != 0 && err != 0) m_errs = 1'b1;
        m_state = nxt;
    endtask

    task automatic check_all(input string tag);
        bit mp, mp8;
        mp  = (m_state == 3) && (m_err == 0)  && (m_vld != 0);
        mp8 = (m_state == 3) && (m_err8 == 0) && (m_vld8 != 0);
        chk({tag, ".state"},   64'(state),      64'(m_state));
        chk({tag, ".win_cnt"}, 64'(win_cnt),    64'(m_wcnt));
        chk({tag, ".win_err"}, 64'(win_err),    64'(m_werr));
        chk({tag, ".win_idl"}, 64'(win_idl),    64'(m_widl));
        chk({tag, ".tot_vld"}, 64'(tot_vld),    m_vld);
        chk({tag, ".tot_err"}, 64'(tot_err),    m_err);
        chk({tag, ".tot_idl"}, 64'(tot_idl),    m_idl);
        chk({tag, ".lat"},     64'(lat),        64'(m_lat));
        chk({tag, ".sat"},     64'(sat),        64'(m_sat));
        chk({tag, ".errs"},    64'(err_sticky), 64'(m_errs));
        chk({tag, ".pass"},    64'(pass),       64'(mp));
        chk({tag, ".state8"},  64'(state8),     64'(m_state));
        chk({tag, ".vld8"},    64'(tot_vld8),   m_vld8);
        chk({tag, ".err8"},    64'(tot_err8),   m_err8);
        chk({tag, ".idl8"},    64'(tot_idl8),   m_idl8);
        chk({tag, ".sat8"},    64'(sat8),       64'(m_sat8));
        chk({tag, ".pass8"},   64'(pass8),      64'(mp8));
    endtask

    // Present one window, toggle, wait (bounded) for upd and check everything
    task automatic win(input int cnt, input int err, input int idl, input int lt, input bit done,
                       input string tag);
        int seen;
        @(negedge clk);
        mon_cnt = 7'(cnt); mon_err = 7'(err); mon_idl = 12'(idl);
        mon_lat = 16'(lt); mon_done = done;
        mon_vld_tgl = ~mon_vld_tgl;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (upd) begin
                seen = i;
                break;
            end
        end
        if (seen != 0) n_upd++;
        chk({tag, ".upd_latency"}, 64'(seen), 64'(SYNC + 1));
        chk({tag, ".upd8"}, 64'(upd8), 64'(seen != 0));
        model_win(cnt, err, idl, lt, done);
        check_all(tag);
        @(negedge clk);
        chk({tag, ".upd_width"}, 64'(upd), 64'd0);
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        chk("clr.upd", 64'(upd), 64'd0);
        check_all("clr");
    endtask

    task automatic count_upd(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (upd) pulses++;
        end
    endtask

    initial begin
        int pulses;
        rstn = 1'b0; clr = 1'b0; mon_vld_tgl = 1'b0;
        mon_cnt = '0; mon_err = '0; mon_idl = '0; mon_lat = '0; mon_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset.upd", 64'(upd), 64'd0);
        check_all("reset");
        rstn = 1'b1;
        repeat (6) @(negedge clk);

        // Bring-up sequence: IDLE -> WAIT -> RUN -> RUN
        n_upd = 0;
        win(0, 0, 0, 100, 1'b0, "w1");
        chk("w1.state", 64'(state), 64'd1);
        win(64, 0, 0, 120, 1'b0, "w2");
        chk("w2.state", 64'(state), 64'd2);
        win(32, 0, 32, 130, 1'b0, "w3");
        chk("w3.state", 64'(state), 64'd2);
        chk("w3.tot_vld", 64'(tot_vld), 64'd96);
        chk("w3.tot_idl", 64'(tot_idl), 64'd32);
        chk("w3.pulses", 64'(n_upd), 64'd3);

        // Error window then done
        win(64, 5, 0, 7, 1'b0, "e1");
        chk("e1.err_sticky", 64'(err_sticky), 64'd1);
        chk("e1.tot_err", 64'(tot_err), 64'd5);
        win(0, 0, 0, 9, 1'b1, "e2");
        chk("e2.state", 64'(state), 64'd3);
        chk("e2.pass", 64'(pass), 64'd0);

        // Clean run, then restart from DONE
        do_clr();
        win(0, 0, 0, 50, 1'b0, "c0");
        for (int i = 0; i < 4; i++) win(64, 0, 3, 50 + i, 1'b0, "c");
        chk("c.tot_vld", 64'(tot_vld), 64'd256);
        win(0, 0, 0, 60, 1'b1, "cd");
        chk("cd.state", 64'(state), 64'd3);
        chk("cd.pass", 64'(pass), 64'd1);
        chk("cd.tot_err", 64'(tot_err), 64'd0);
        win(10, 0, 0, 61, 1'b0, "cr");
        chk("cr.state", 64'(state), 64'd2);
        chk("cr.tot_vld", 64'(tot_vld), 64'd266);

        // Saturation on the 8-bit instance
        do_clr();
        win(0, 0, 0, 1, 1'b0, "s0");
        win(100, 0, 0, 1, 1'b0, "s1");
        chk("s1.vld8", 64'(tot_vld8), 64'd100);
        win(100, 0, 0, 1, 1'b0, "s2");
        chk("s2.vld8", 64'(tot_vld8), 64'd200);
        chk("s2.sat8", 64'(sat8), 64'd0);
        win(100, 0, 0, 1, 1'b0, "s3");
        chk("s3.vld8", 64'(tot_vld8), 64'd255);
        chk("s3.sat8", 64'(sat8), 64'd1);
        win(1, 0, 0, 1, 1'b0, "s4");
        chk("s4.sat8", 64'(sat8), 64'd1);
        chk("s4.sat32", 64'(sat), 64'd0);

        // clr coinciding with the detect cycle discards the window
        @(negedge clk);
        mon_cnt = 7'd20; mon_err = 7'd1; mon_idl = 12'd5; mon_done = 1'b0;
        mon_vld_tgl = ~mon_vld_tgl;
        repeat (SYNC) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        count_upd(10, pulses);
        chk("clrdet.pulses", 64'(pulses), 64'd0);
        check_all("clrdet");
        win(0, 0, 0, 2, 1'b0, "clrdet_next");
        chk("clrdet_next.state", 64'(state), 64'd1);

        // Two toggles in flight: one update each
        win(8, 0, 1, 3, 1'b0, "bb0");
        @(negedge clk);
        mon_cnt = 7'd5; mon_err = 7'd0; mon_idl = 12'd7; mon_lat = 16'd44; mon_done = 1'b0;
        mon_vld_tgl = ~mon_vld_tgl;
        @(negedge clk);
        @(negedge clk);
        mon_vld_tgl = ~mon_vld_tgl;
        count_upd(12, pulses);
        chk("bb.pulses", 64'(pulses), 64'd2);
        model_win(5, 0, 7, 44, 1'b0);
        model_win(5, 0, 7, 44, 1'b0);
        check_all("bb");

        // Reset mid-run with the toggle input held high
        if (mon_vld_tgl == 1'b0) win(3, 0, 0, 4, 1'b0, "pre_rst");
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        chk("arst.upd", 64'(upd), 64'd0);
        check_all("arst");
        @(negedge clk);
        rstn = 1'b1;
        count_upd(15, pulses);
        chk("arst.pulses", 64'(pulses), 64'd0);
        check_all("arst_rel");
        win(0, 0, 0, 5, 1'b0, "arst_next");
        chk("arst_next.state", 64'(state), 64'd1);

        // Random windows with occasional clears
        for (int k = 0; k < 80; k++) begin
            int c, e, d;
            c = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 127));
            e = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 127)) : 0;
            d = ($urandom_range(0, 2) == 0) ? 1 : 0;
            if ($urandom_range(0, 19) == 0) do_clr();
            win(c, e, int'($urandom_range(0, 4095)), int'($urandom_range(0, 65535)), d[0], "rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tst_dout_stat.md
TST_DOUT_STAT -- requirements
Module: tst_dout_stat

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the toggle-synchronizer depth; legal range 2..4.
REQ-002 Parameter ACCW, default 32, SHALL set the width of the tot_vld and tot_err accumulators; tot_idl SHALL be ACCW+8 bits.
REQ-003 clk  in  1  slow register-domain clock; the only clock of the block.
REQ-004 rstn  in  1  reset, asynchronous assert, active-low.
REQ-005 clr  in  1  synchronous clear of all statistics and the FSM, active-high.
REQ-006 mon_vld_tgl  in  1  window-update toggle from the fast-domain output monitor; asynchronous to clk.
REQ-007 mon_cnt  in  7  valid count of the last 64-cycle window.
REQ-008 mon_err  in  7  mismatch count of the last window.
REQ-009 mon_idl  in  12  idle-cycle sum of the last window.
REQ-010 mon_lat  in  16  cycles from monitor start to first output.
REQ-011 mon_done  in  1  fast-domain idle-timeout flag.
REQ-012 upd  out  1  one-cycle pulse; all capture outputs changed this cycle.
REQ-013 win_cnt / win_err / win_idl  out  7/7/12  last captured window values.
REQ-014 tot_vld / tot_err  out  ACCW  saturating running totals.
REQ-015 tot_idl  out  ACCW+8  saturating running idle total.
REQ-016 lat  out  16  captured first-output latency.
REQ-017 sat  out  1  sticky; set when any accumulator saturates.
REQ-018 err_sticky  out  1  sticky; set when any window reports mon_err != 0.
REQ-019 state  out  2  FSM state: 0 IDLE, 1 WAIT, 2 RUN, 3 DONE.
REQ-020 pass  out  1  high iff state==DONE, tot_err==0, tot_vld!=0.

Function
REQ-021 mon_vld_tgl SHALL pass through SYNC_STAGES flops, then one extra delay flop; upd_det = XOR of the last sync stage and the delay flop.
REQ-022 Other mon_* buses SHALL NOT be synchronized; they SHALL be sampled only on upd_det, relying on their 64-fast-cycle stability.
REQ-023 Integration constraint: (SYNC_STAGES+2) clk periods SHALL be less than 64 fast-clock periods.
REQ-024 When upd_det is high at edge N, all captures, accumulations and FSM moves SHALL be visible after edge N, and upd SHALL be high for exactly that following cycle.
REQ-025 win_* SHALL capture the mon_* values on every upd_det, in all states.
REQ-026 In RUN, and on the WAIT->RUN transition, tot_vld += mon_cnt, tot_err += mon_err, tot_idl += mon_idl.
REQ-027 Each accumulation SHALL saturate at all-ones and set sat; it SHALL never wrap.
REQ-028 lat SHALL capture mon_lat on every upd_det while state is WAIT or RUN; it SHALL freeze in IDLE and DONE.
REQ-029 err_sticky SHALL set on any upd_det with mon_err != 0 while state != IDLE.
REQ-030 FSM transitions, each evaluated on upd_det:
- IDLE -> WAIT on any update.
- WAIT -> RUN when mon_cnt != 0.
- RUN -> DONE when mon_done==1 and mon_cnt==0.
- DONE -> RUN when mon_cnt != 0; totals keep accumulating.
- Otherwise hold.
REQ-031 In IDLE, updates SHALL only refresh win_*.
REQ-032 clr SHALL clear everything except the synchronizer chain; it SHALL return the FSM to IDLE next cycle and suppress upd.
REQ-033 clr and upd_det in the same cycle: clr wins and the window is discarded.
REQ-034 A toggle arriving while the synchronizer still holds the previous edge SHALL yield one upd per toggle, with no merging and no loss.

Reset
REQ-035 rstn low SHALL asynchronously clear all registers, including the synchronizer chain, to 0: state=IDLE, upd=0, pass=0, sat=0, err_sticky=0, all buses 0.
REQ-036 On rstn deassertion the first mon_vld_tgl level SHALL NOT generate upd; only a toggle after reset SHALL.
REQ-037 Reset asserted mid-run SHALL discard totals; no partial update SHALL be emitted.

Verification
REQ-038 Reset, then 3 toggles with (cnt,err,idl) = (0,0,0), (64,0,0), (32,0,32) -> state IDLE->WAIT->RUN->RUN; tot_vld=96, tot_idl=32, upd pulses=3.
REQ-039 In RUN, window (64,5,0) -> err_sticky=1, tot_err=5; a following window (0,0,0) with mon_done=1 -> state=DONE, pass=0.
REQ-040 Clean run of 4 windows of 64 then done -> tot_vld=256, tot_err=0, state=DONE, pass=1; a further window (10,0,0) -> state=RUN, tot_vld=266.
REQ-041 ACCW=8, windows of cnt=100 -> tot_vld = 100, 200, 255; sat=1 after the third window and stays set.
REQ-042 clr asserted in the same cycle as upd_det -> no upd pulse, state=IDLE, all totals 0; the next toggle -> state=WAIT.
REQ-043 rstn pulsed low mid-RUN while mon_vld_tgl=1 -> all outputs 0 immediately; no upd after release until the next toggle.
